// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment scanner.
// Glyphs are active-high, bit0 = segment a ... bit6 = segment g.
package seg7_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] digit_t;

  localparam digit_t SEG_GLYPH [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  function automatic digit_t seg7_glyph(input nibble_t n);
    return SEG_GLYPH[n];
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host-side load bus and board-side display pins of the scanner.
// master = confreg/host side, slave = the display controller.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS   = 8,
  parameter int BRIGHT_WIDTH = 4
);

  logic                      load;
  logic [4*NUM_DIGITS-1:0]   data_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [NUM_DIGITS-1:0]     blank_in;
  logic                      lz_suppress;
  logic [BRIGHT_WIDTH-1:0]   brightness;
  logic [NUM_DIGITS-1:0]     an;
  logic [6:0]                seg;
  logic                      dp;
  logic                      frame_done;

  modport master (
    output load, data_in, dp_in, blank_in,
    output lz_suppress, brightness,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  load, data_in, dp_in, blank_in,
    input  lz_suppress, brightness,
    output an, seg, dp, frame_done
  );

endinterface

// File: rtl/seg7_scan_timer.sv
// Slot prescaler and digit index; tick marks the last cycle of a frame,
// the same cycle in which the index is about to wrap back to 0.
module seg7_scan_timer #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_WIDTH  = 15,
  parameter int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [DIV_WIDTH-1:0] phase,
  output logic [IW-1:0]        idx,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] phase_q, phase_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 slot_end;

  always_comb begin
    slot_end = &phase_q;
    tick     = slot_end && (idx_q == IW'(NUM_DIGITS - 1));
    phase_d  = phase_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = tick ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  assign phase = phase_q;
  assign idx   = idx_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment controller: frame-boundary commit, leading-zero
// suppression, PWM brightness and anode guard time, registered pins.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV_WIDTH    = 15,
  parameter int BRIGHT_WIDTH = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int ACTIVE_LOW   = 1
) (
  input logic             clk,
  input logic             reset,
  seg7_scan_ctrl_if.slave bus
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{POL}};
  localparam logic [6:0] SEG_OFF = {7{POL}};

  logic [DIV_WIDTH-1:0]  phase;
  logic [IW-1:0]         idx;
  logic                  tick;

  logic [DW-1:0]         pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DW-1:0]         act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] act_mask_q, act_mask_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;

  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] sel_hot;
  nibble_t               sel_nib;
  logic                  sel_dp, sel_blank;
  logic [BRIGHT_WIDTH-1:0] duty_pos;
  logic                  pwm_on, enable;

  seg7_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIV_WIDTH  (DIV_WIDTH),
    .IW         (IW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .phase (phase),
    .idx   (idx),
    .tick  (tick)
  );

  // A load in the commit cycle bypasses pending and is committed directly.
  always_comb begin
    pend_data_d  = bus.load ? bus.data_in  : pend_data_q;
    pend_dp_d    = bus.load ? bus.dp_in    : pend_dp_q;
    pend_blank_d = bus.load ? bus.blank_in : pend_blank_q;
    pend_valid_d = bus.load | pend_valid_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_mask_d   = act_mask_q;
    if (tick) begin
      pend_valid_d = 1'b0;
      if (bus.load | pend_valid_q) begin
        act_data_d = pend_data_d;
        act_dp_d   = pend_dp_d;
        act_mask_d = pend_blank_d | lz_mask;
      end
    end
  end

  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (pend_data_d[4*i +: 4] == 4'h0);
      if (i > 0) lz_mask[i] = bus.lz_suppress & zero_run;
    end
  end

  always_comb begin
    sel_hot   = '0;
    sel_nib   = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        sel_hot[i] = 1'b1;
        sel_nib    = act_data_q[4*i +: 4];
        sel_dp     = act_dp_q[i];
        sel_blank  = act_mask_q[i];
      end
    end
    duty_pos = phase[DIV_WIDTH-1 -: BRIGHT_WIDTH];
    pwm_on   = (&bus.brightness) | (duty_pos < bus.brightness);
    enable   = (phase >= DIV_WIDTH'(GUARD_CYCLES)) & pwm_on & ~sel_blank;
    an_d     = (enable ? sel_hot : '0) ^ AN_OFF;
    seg_d    = (enable ? seg7_glyph(sel_nib) : 7'h00) ^ SEG_OFF;
    dp_d     = (enable & sel_dp) ^ POL;
    fd_d     = tick;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_valid_q <= 1'b0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_mask_q   <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= POL;
      fd_q         <= 1'b0;
    end else begin
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_valid_q <= pend_valid_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_mask_q   <= act_mask_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      fd_q         <= fd_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: cycle-count reference model plus directed
// literal checks, then randomized loads/brightness/resets.
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int DW = 6;
  localparam int BW = 2;
  localparam int GC = 2;
  localparam int AL = 1;
  localparam int SLOT  = 64;
  localparam int FRAME = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.NUM_DIGITS(N), .BRIGHT_WIDTH(BW)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS   (N),
    .DIV_WIDTH    (DW),
    .BRIGHT_WIDTH (BW),
    .GUARD_CYCLES (GC),
    .ACTIVE_LOW   (AL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  logic [6:0] glyph [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Reference model: k counts cycles since reset release; slot and digit
  // follow directly from k, pins lag the state by one cycle.
  int         k;
  int         ph, ix;
  bit         en, mval = 0;
  bit         pv;
  logic [15:0] pd, ad, tmp;
  logic [3:0]  pdp, pbl, adp, am;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;

  always begin
    @(posedge clk);
    if (reset) begin
      k = 0; pv = 0; pd = 0; pdp = 0; pbl = 0;
      ad = 0; adp = 0; am = 0;
      e_an = 4'hf; e_seg = 7'h7f; e_dp = 1'b1; e_fd = 1'b0;
      mval = 1;
    end else begin
      ph  = k % SLOT;
      ix  = (k / SLOT) % N;
      en  = (ph >= GC) &&
            (bus.brightness == 2'd3 || (ph / 16) < bus.brightness) &&
            !am[ix];
      tmp = ad >> (4 * ix);
      e_an  = en ? ~(4'b0001 << ix) : 4'hf;
      e_seg = en ? ~glyph[tmp[3:0]] : 7'h7f;
      e_dp  = en ? ~adp[ix] : 1'b1;
      e_fd  = (k % FRAME) == FRAME - 1;
      if (bus.load) begin
        pd = bus.data_in; pdp = bus.dp_in; pbl = bus.blank_in; pv = 1;
      end
      if (e_fd && pv) begin
        ad = pd; adp = pdp; am = pbl;
        for (int i = 1; i < N; i++)
          if (bus.lz_suppress && (pd >> (4 * i)) == 16'h0) am[i] = 1'b1;
        pv = 0;
      end
      k++;
    end
    @(negedge clk);
    if (mval) begin
      chk("an", bus.an, e_an);
      chk("seg", bus.seg, e_seg);
      chk("dp", bus.dp, e_dp);
      chk("frame_done", bus.frame_done, e_fd);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    while (bus.frame_done !== 1'b1 && n < 600) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dpv,
                         input logic [3:0] bl, input logic lz);
    bus.load = 1'b1; bus.data_in = d; bus.dp_in = dpv;
    bus.blank_in = bl; bus.lz_suppress = lz;
    cyc(1);
    bus.load = 1'b0;
  endtask

  int n, cnt, bad;
  logic [15:0] msk;
  logic [15:0] masks [4] = '{16'hffff, 16'h00ff, 16'h000f, 16'h0000};

  initial begin
    bus.load = 0; bus.data_in = 0; bus.dp_in = 0; bus.blank_in = 0;
    bus.lz_suppress = 0; bus.brightness = 2'd3;
    reset = 1'b1;
    cyc(3);
    chk("rst_an", bus.an, 4'hf);
    chk("rst_seg", bus.seg, 7'h7f);
    chk("rst_dp", bus.dp, 1'b1);
    chk("rst_fd", bus.frame_done, 1'b0);
    reset = 1'b0;
    cyc(3);
    chk("first_an", bus.an, 4'b1110);
    chk("first_seg", bus.seg, 7'b1000000);
    cyc(97);
    do_load(16'h1234, 4'h0, 4'h0, 1'b0);
    chk("f0_an", bus.an, 4'b1101);
    chk("f0_seg", bus.seg, 7'b1000000);
    wait_fd(n);
    chk("first_fd_at", n + 101, 256);
    cyc(10);
    chk("d0_an", bus.an, 4'b1110);
    chk("d0_seg", bus.seg, 7'b0011001);
    cyc(193);
    chk("d3_an", bus.an, 4'b0111);
    chk("d3_seg", bus.seg, 7'b1111001);

    // Brightness 1 and 0 over whole frames.
    wait_fd(n);
    bus.brightness = 2'd1;
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      cyc(1);
      if (bus.an != 4'hf) cnt++;
    end
    chk("bright1_on", cnt, 56);
    bus.brightness = 2'd0;
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      cyc(1);
      if (bus.an != 4'hf) cnt++;
    end
    chk("bright0_on", cnt, 0);
    bus.brightness = 2'd3;

    // Leading-zero suppression.
    do_load(16'h0050, 4'h0, 4'h0, 1'b1);
    wait_fd(n);
    cnt = 0;
    for (int i = 1; i <= FRAME; i++) begin
      cyc(1);
      if (bus.an[3] == 1'b0 || bus.an[2] == 1'b0) cnt++;
      if (i == 10) chk("lz_d0_seg", bus.seg, 7'b1000000);
      if (i == 74) chk("lz_d1_seg", bus.seg, 7'b0010010);
    end
    chk("lz_hi_dark", cnt, 0);
    do_load(16'h0000, 4'h0, 4'h0, 1'b1);
    wait_fd(n);
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      cyc(1);
      if (bus.an[3:1] != 3'b111) cnt++;
    end
    chk("lz_zero_only_d0", cnt, 0);

    // Last load in a frame wins.
    bus.lz_suppress = 1'b0;
    do_load(16'hAAAA, 4'h0, 4'h0, 1'b0);
    cyc(5);
    do_load(16'hBBBB, 4'h0, 4'h0, 1'b0);
    wait_fd(n);
    cnt = 0; bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      cyc(1);
      if (bus.an != 4'hf) begin
        cnt++;
        if (bus.seg != 7'b0000011) bad++;
      end
    end
    chk("last_wins_bad", bad, 0);
    chk("last_wins_lit", cnt, 4 * 62);

    // Load in the commit cycle itself.
    wait_fd(n);
    cyc(255);
    do_load(16'hCCCC, 4'h0, 4'h0, 1'b0);
    cyc(10);
    chk("edge_load_seg", bus.seg, 7'b1000110);

    // Reset mid-frame discards pending data.
    cyc(40);
    do_load(16'h9999, 4'hf, 4'h0, 1'b0);
    cyc(20);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    wait_fd(n);
    chk("rst_fd_at", n, 256);
    cyc(10);
    chk("rst_d0_seg", bus.seg, 7'b1000000);
    chk("rst_d0_dp", bus.dp, 1'b1);

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        msk = masks[$urandom_range(0, 3)];
        bus.load = 1'b1;
        bus.data_in = 16'($urandom) & msk;
        bus.dp_in = 4'($urandom);
        bus.blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        bus.lz_suppress = 1'($urandom);
      end else begin
        bus.load = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) bus.brightness = 2'($urandom);
      reset = ($urandom_range(0, 1999) == 0);
      cyc(1);
    end
    bus.load = 1'b0;
    reset = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed 7-segment display controller for the SoC board top level. It latches an N-digit hex value with decimal points and blank mask, and scans one digit per time slot. Added behaviour: tear-free frame-boundary commit, leading-zero suppression, PWM brightness and anode guard time. Sits between confreg display data and the board AN/A2G/DP pins.

Parameters:
NUM_DIGITS, 8, number of digits/anodes (>=1)
DIV_WIDTH, 15, prescaler width; one digit slot = 2^DIV_WIDTH cycles
BRIGHT_WIDTH, 4, brightness control width (DIV_WIDTH >= BRIGHT_WIDTH+1)
GUARD_CYCLES, 2, anode-off cycles at slot start (< 2^(DIV_WIDTH-BRIGHT_WIDTH))
ACTIVE_LOW, 1, 1 = an/seg/dp pins active-low, 0 = active-high

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
load  in  1  one-cycle strobe: capture data_in/dp_in/blank_in into pending
data_in  in  4*NUM_DIGITS  hex nibbles; digit i = bits [4i+3:4i], digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point per digit
blank_in  in  NUM_DIGITS  1 = force digit dark
lz_suppress  in  1  enable leading-zero suppression (sampled at commit)
brightness  in  BRIGHT_WIDTH  duty level, live (not shadowed)
an  out  NUM_DIGITS  anode selects, at most one active
seg  out  7  segments, bit0=a ... bit6=g
dp  out  1  decimal point
frame_done  out  1  one-cycle pulse when last digit slot ends

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Prescaler counts 0..2^DIV_WIDTH-1 and wraps. At terminal count, the digit index advances. Index wraps NUM_DIGITS-1 -> 0. frame_done is high in the cycle where the index is updated to 0.
- Registers: pending (data, dp, blank, valid flag) and active (data, dp, effective blank mask).
- Commit: on the frame_done cycle, if pending valid, pending -> active and valid cleared. The effective mask is blank_in OR lz mask, computed at commit.
- LZ mask: digit i (i>0) suppressed iff lz_suppress and all nibbles at i..NUM_DIGITS-1 are zero. Digit 0 is never suppressed by LZ. dp of an LZ-suppressed digit is also dark.
- Load and frame_done in the same cycle: the new load data is committed directly. Multiple loads in one frame: last one wins.
- Digit enable = (prescaler >= GUARD_CYCLES) AND pwm_on AND NOT eff_blank[idx].
- pwm_on: true if brightness is all ones. Otherwise true iff prescaler[DIV_WIDTH-1 -: BRIGHT_WIDTH] < brightness. brightness 0 = dark.
- When enabled: an = one-hot(idx), seg = hex glyph of the active nibble, dp = dp bit. When disabled: all inactive.
- Glyphs (active-high, bit6..0): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001. Outputs are inverted when ACTIVE_LOW=1.
- Outputs are registered: one cycle latency from prescaler/index state to pins.
- Reset: prescaler 0, idx 0, pending cleared and invalid, active data/dp/mask 0, frame_done 0. an/seg/dp are inactive (ACTIVE_LOW=1: all ones).
- Reset mid-frame discards pending data and restarts at slot 0.

Decomposition:
- Package seg7_pkg:
  - SEG_GLYPH constant table (16 x 7, active-high);
  - function seg7_glyph(nibble);
  - digit_t/nibble_t typedefs.
- One sub-module, seg7_scan_timer: prescaler + digit index + frame_done. Outputs phase, idx and tick.

Test Plan:
Concrete values use NUM_DIGITS=4, DIV_WIDTH=6, BRIGHT_WIDTH=2, GUARD_CYCLES=2, ACTIVE_LOW=1; slot = 64 cycles, frame = 256 cycles.
1. Reset held 3 cycles -> an=1111, seg=1111111, dp=1, frame_done=0. After release with brightness=3, an=1110, seg=1000000 from the 3rd cycle; first frame_done 256 cycles after release.
2. load data=0x1234, brightness=3 at cycle 100 -> frame 0 still shows 0000. After frame_done: digit0 seg=0011001 (4) and digit3 seg=1111001 (1).
3. lz_suppress=1, data=0x0050 -> an[3] and an[2] never low over the frame; digit1 seg=0010010, digit0 seg=1000000. data=0x0000 -> only an[0] ever low.
4. brightness=1 -> an low exactly for prescaler 2..15, i.e. 14 of 64 cycles per slot. brightness=0 -> an=1111 for a full frame.
5. load 0xAAAA then 0xBBBB in the same frame -> all digits seg=0000011. A load on the frame_done cycle itself is visible in the next slot.
6. Pending load, then reset mid-frame -> after release all digits show 0 (none committed); frame_done 256 cycles after release.
